// File: rtl/pipeline_ctrl_if.sv
//------------------------------------------------------------------------------
// pipeline_ctrl_if
//
// Bundle of every control signal exchanged between the pipeline sequencer and
// the rest of the 5-stage LEGv8 core (hazard unit, data-memory port, debug
// port, pipeline registers and PC register).
//
// Parameter
//   CNT_W        width of the stall / flush performance counters
//
// Signals (direction as seen by the sequencer, i.e. the slave modport)
//   hdu_stall     in   load-use stall request from the hazard unit
//   mem_br_taken  in   branch resolved taken in MEM
//   dmem_req      in   MEM-stage instruction accesses data memory
//   dmem_ready    in   data memory completes the access this cycle
//   halt_req      in   debug halt request (level)
//   pc_en         out  PC register load enable
//   ifid_en       out  IF/ID load enable
//   ifid_flush    out  IF/ID clear to NOP (wins over enable)
//   idex_en       out  ID/EX load enable
//   idex_flush    out  ID/EX clear to bubble (wins over enable)
//   exmem_en      out  EX/MEM load enable
//   exmem_flush   out  EX/MEM clear to bubble
//   memwb_bubble  out  MEM/WB loads a bubble
//   halted        out  sequencer is in the halted state
//   mem_timeout   out  sticky memory-wait timeout flag
//   stall_cnt     out  saturating stall-cycle counter
//   flush_cnt     out  saturating branch-flush counter
//
// Modports
//   master : the core side that raises requests and consumes the controls
//   slave  : the sequencer itself
//------------------------------------------------------------------------------
interface pipeline_ctrl_if #(
   parameter int CNT_W = 16
);
   // requests into the sequencer
   logic             hdu_stall;
   logic             mem_br_taken;
   logic             dmem_req;
   logic             dmem_ready;
   logic             halt_req;

   // per-register controls out of the sequencer
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_flush;
   logic             exmem_en;
   logic             exmem_flush;
   logic             memwb_bubble;

   // status and performance counters
   logic             halted;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output hdu_stall,
      output mem_br_taken,
      output dmem_req,
      output dmem_ready,
      output halt_req,
      input  pc_en,
      input  ifid_en,
      input  ifid_flush,
      input  idex_en,
      input  idex_flush,
      input  exmem_en,
      input  exmem_flush,
      input  memwb_bubble,
      input  halted,
      input  mem_timeout,
      input  stall_cnt,
      input  flush_cnt
   );

   modport slave (
      input  hdu_stall,
      input  mem_br_taken,
      input  dmem_req,
      input  dmem_ready,
      input  halt_req,
      output pc_en,
      output ifid_en,
      output ifid_flush,
      output idex_en,
      output idex_flush,
      output exmem_en,
      output exmem_flush,
      output memwb_bubble,
      output halted,
      output mem_timeout,
      output stall_cnt,
      output flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
//------------------------------------------------------------------------------
// pipeline_ctrl
//
// Central sequencer for the 5-stage LEGv8 pipeline (IF/ID/EX/MEM/WB).
// Merges the load-use stall request, the taken-branch flush from MEM and the
// data-memory wait handshake into per-register enable / flush controls for
// the PC and every pipeline register. It also implements a debug halt and
// keeps saturating stall / flush performance counters.
//
// Parameters
//   CNT_W        width of stall_cnt / flush_cnt (saturating)
//   MEM_TIMEOUT  number of memory-wait cycles after which mem_timeout latches
//
// Ports
//   clk     in   rising-edge clock, the only clock
//   reset   in   synchronous, active-high reset
//   ctrl    slave modport of pipeline_ctrl_if carrying all requests,
//           register controls, status flags and counters
//
// Control outputs are combinational from the registered state and the
// current requests; state, counters, halted and mem_timeout are registered.
//------------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   pipeline_ctrl_if.slave   ctrl
);

   //---------------------------------------------------------------------------
   // Local parameters
   //---------------------------------------------------------------------------
   // The wait counter only has to reach MEM_TIMEOUT; it holds there afterwards
   // so it can never wrap and re-arm the comparison.
   localparam int               WAIT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALTED   = 2'd2
   } state_t;

   //---------------------------------------------------------------------------
   // Registers and next-state values
   //---------------------------------------------------------------------------
   state_t              state_q,     state_d;
   logic [WAIT_W-1:0]   wait_cnt_q,  wait_cnt_d;
   logic                timeout_q,   timeout_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

   //---------------------------------------------------------------------------
   // Request decode
   //---------------------------------------------------------------------------
   logic hdu_stall;
   logic br_taken;
   logic halt_req;
   logic mem_stall;

   assign hdu_stall = ctrl.hdu_stall;
   assign br_taken  = ctrl.mem_br_taken;
   assign halt_req  = ctrl.halt_req;

   // An outstanding data-memory access freezes everything up to EX/MEM.
   assign mem_stall = ctrl.dmem_req & ~ctrl.dmem_ready;

   //---------------------------------------------------------------------------
   // Per-register controls (priority: memory wait, branch, load-use, run)
   //---------------------------------------------------------------------------
   logic pc_en;
   logic ifid_en;
   logic ifid_flush;
   logic idex_en;
   logic idex_flush;
   logic exmem_en;
   logic exmem_flush;
   logic memwb_bubble;
   logic stall_hit;     // this cycle counts as a stall cycle
   logic flush_hit;     // this cycle is a branch flush event

   always_comb begin
      // Default is the fully frozen pattern used while halted.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_en      = 1'b0;
      idex_flush   = 1'b0;
      exmem_en     = 1'b0;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b1;
      stall_hit    = 1'b0;
      flush_hit    = 1'b0;

      if (reset) begin
         // Clear every pipeline register to a bubble while in reset.
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (state_q != ST_HALTED) begin
         if (mem_stall) begin
            // Freeze PC..EX/MEM and keep the waiting access in MEM; a branch
            // sitting in EX/MEM is held and fires once the memory is ready.
            stall_hit = 1'b1;
         end else if (br_taken) begin
            // Redirect the PC and squash the three younger instructions. A
            // simultaneous load-use stall is dropped: its consumer is one of
            // the squashed instructions.
            pc_en        = 1'b1;
            ifid_en      = 1'b1;
            idex_en      = 1'b1;
            exmem_en     = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b0;
            flush_hit    = 1'b1;
         end else if (hdu_stall) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX and let the load
            // move on. idex_en is left high; the flush overrides it anyway.
            idex_en      = 1'b1;
            idex_flush   = 1'b1;
            exmem_en     = 1'b1;
            memwb_bubble = 1'b0;
            stall_hit    = 1'b1;
         end else begin
            pc_en        = 1'b1;
            ifid_en      = 1'b1;
            idex_en      = 1'b1;
            exmem_en     = 1'b1;
            memwb_bubble = 1'b0;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Next state, wait counter, timeout flag and performance counters
   //---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      // Saturating counters: they stick at all-ones instead of wrapping.
      if (stall_hit && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush_hit && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end

      case (state_q)
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_stall) begin
               // A halt request is not honoured until the access finishes.
               state_d = ST_MEM_WAIT;
               if (wait_cnt_q != WAIT_LIMIT) begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
               // Latch when this wait cycle brings the count to the limit;
               // the flag then stays set until reset.
               if ((wait_cnt_q + 1'b1) >= WAIT_LIMIT) begin
                  timeout_d = 1'b1;
               end
            end else begin
               wait_cnt_d = '0;
               // Halt is only taken from RUN; the cycle that leaves MEM_WAIT
               // always returns to RUN first.
               if ((state_q == ST_RUN) && halt_req) begin
                  state_d = ST_HALTED;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_HALTED: begin
            if (!halt_req) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   //---------------------------------------------------------------------------
   // Output drive
   //---------------------------------------------------------------------------
   assign ctrl.pc_en        = pc_en;
   assign ctrl.ifid_en      = ifid_en;
   assign ctrl.ifid_flush   = ifid_flush;
   assign ctrl.idex_en      = idex_en;
   assign ctrl.idex_flush   = idex_flush;
   assign ctrl.exmem_en     = exmem_en;
   assign ctrl.exmem_flush  = exmem_flush;
   assign ctrl.memwb_bubble = memwb_bubble;
   assign ctrl.halted       = (state_q == ST_HALTED);
   assign ctrl.mem_timeout  = timeout_q;
   assign ctrl.stall_cnt    = stall_cnt_q;
   assign ctrl.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
//------------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Two sequencers are driven with identical requests: dut_a with the default
// parameters (CNT_W=16, MEM_TIMEOUT=64) and dut_b with CNT_W=3, MEM_TIMEOUT=4
// so that counter saturation and the wait timeout are reachable quickly.
// A table of per-cycle vectors covers the main rules; short hand-written
// sequences cover timeout, saturation and reset out of MEM_WAIT / HALTED.
//------------------------------------------------------------------------------
module tb_pipeline_ctrl;

   logic clk;
   logic reset;

   // shared request inputs
   logic hdu_stall, mem_br_taken, dmem_req, dmem_ready, halt_req;

   pipeline_ctrl_if #(.CNT_W(16)) ifa ();
   pipeline_ctrl_if #(.CNT_W(3))  ifb ();

   pipeline_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64)) dut_a (
      .clk   (clk),
      .reset (reset),
      .ctrl  (ifa.slave)
   );

   pipeline_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut_b (
      .clk   (clk),
      .reset (reset),
      .ctrl  (ifb.slave)
   );

   assign ifa.hdu_stall    = hdu_stall;
   assign ifa.mem_br_taken = mem_br_taken;
   assign ifa.dmem_req     = dmem_req;
   assign ifa.dmem_ready   = dmem_ready;
   assign ifa.halt_req     = halt_req;
   assign ifb.hdu_stall    = hdu_stall;
   assign ifb.mem_br_taken = mem_br_taken;
   assign ifb.dmem_req     = dmem_req;
   assign ifb.dmem_ready   = dmem_ready;
   assign ifb.halt_req     = halt_req;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
   //  memwb_bubble, halted, mem_timeout}
   logic [9:0] out_a, out_b;
   assign out_a = {ifa.pc_en, ifa.ifid_en, ifa.ifid_flush, ifa.idex_en,
                   ifa.idex_flush, ifa.exmem_en, ifa.exmem_flush,
                   ifa.memwb_bubble, ifa.halted, ifa.mem_timeout};
   assign out_b = {ifb.pc_en, ifb.ifid_en, ifb.ifid_flush, ifb.idex_en,
                   ifb.idex_flush, ifb.exmem_en, ifb.exmem_flush,
                   ifb.memwb_bubble, ifb.halted, ifb.mem_timeout};

   // expected output patterns
   localparam logic [9:0] O_RST  = 10'b0010101100;
   localparam logic [9:0] O_NORM = 10'b1101010000;
   localparam logic [9:0] O_LU   = 10'b0001110000;
   localparam logic [9:0] O_BR   = 10'b1111111000;
   localparam logic [9:0] O_MW   = 10'b0000000100;
   localparam logic [9:0] O_HLT  = 10'b0000000110;

   localparam logic [9:0] M_ALL  = 10'b1111111111;
   localparam logic [9:0] M_LU   = 10'b1110111111;  // idex_en is don't-care
   localparam logic [9:0] M_NOST = 10'b1111111100;  // status not yet defined

   // input patterns {reset, hdu_stall, mem_br_taken, dmem_req, dmem_ready, halt_req}
   localparam logic [5:0] I_IDLE = 6'b000000;
   localparam logic [5:0] I_RST  = 6'b100000;
   localparam logic [5:0] I_HDU  = 6'b010000;
   localparam logic [5:0] I_BR   = 6'b001000;
   localparam logic [5:0] I_MW   = 6'b000100;
   localparam logic [5:0] I_MRDY = 6'b000110;
   localparam logic [5:0] I_HALT = 6'b000001;

   typedef struct {
      logic [5:0] in;
      logic [9:0] exp;
      logic [9:0] mask;
      int         stall;   // -1: not checked
      int         flush;   // -1: not checked
   } vec_t;

   vec_t vq[$];

   int n_vec = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic add(input logic [5:0] i, input logic [9:0] e,
                      input logic [9:0] m, input int s, input int f);
      vec_t v;
      v.in = i; v.exp = e; v.mask = m; v.stall = s; v.flush = f;
      vq.push_back(v);
   endtask

   // Apply one cycle of inputs just after a rising edge and return at the
   // following falling edge, where outputs are sampled.
   task automatic set_in(input logic [5:0] v);
      @(posedge clk);
      #1;
      {reset, hdu_stall, mem_br_taken, dmem_req, dmem_ready, halt_req} = v;
      @(negedge clk);
   endtask

   task automatic chk_out(input string name, input logic [9:0] act,
                          input logic [9:0] exp, input logic [9:0] mask);
      n_vec++;
      if (((act ^ exp) & mask) !== 10'b0) begin
         n_err++;
         $display("FAIL %s: outputs got %b required %b (mask %b)",
                  name, act, exp, mask);
      end
   endtask

   task automatic chk_val(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      {hdu_stall, mem_br_taken, dmem_req, dmem_ready, halt_req} = '0;

      //---------------- vector table ----------------
      add(I_RST,  O_RST,  M_NOST, -1, -1);  // 0 first reset cycle
      add(I_RST,  O_RST,  M_ALL,   0,  0);  // 1 reset, state settled
      add(I_IDLE, O_NORM, M_ALL,   0,  0);  // 2
      add(I_HDU,  O_LU,   M_LU,    0,  0);  // 3 T1 load-use
      add(I_IDLE, O_NORM, M_ALL,   1,  0);  // 4
      add(I_MW,   O_MW,   M_ALL,   1,  0);  // 5 T2 wait 1
      add(I_MW,   O_MW,   M_ALL,   2,  0);  // 6 wait 2
      add(I_MW,   O_MW,   M_ALL,   3,  0);  // 7 wait 3
      add(I_MRDY, O_NORM, M_ALL,   4,  0);  // 8 ready -> run
      add(I_IDLE, O_NORM, M_ALL,   4,  0);  // 9
      add(I_BR | I_HDU, O_BR, M_ALL, 4, 0); // 10 T3 branch beats load-use
      add(I_IDLE, O_NORM, M_ALL,   4,  1);  // 11
      add(I_BR | I_MW,   O_MW, M_ALL, 4, 1);// 12 branch frozen behind wait
      add(I_BR | I_MRDY, O_BR, M_ALL, 5, 1);// 13 branch fires on ready
      add(I_IDLE, O_NORM, M_ALL,   5,  2);  // 14
      add(I_HALT, O_NORM, M_ALL,   5,  2);  // 15 T5 halt seen in RUN
      add(I_HALT, O_HLT,  M_ALL,   5,  2);  // 16
      add(I_HALT | I_HDU | I_BR, O_HLT, M_ALL, 5, 2); // 17 frozen counters
      add(I_IDLE, O_HLT,  M_ALL,   5,  2);  // 18 release, still halted
      add(I_IDLE, O_NORM, M_ALL,   5,  2);  // 19 back in RUN
      add(I_HALT | I_BR, O_BR, M_ALL, 5, 2);// 20 halt with branch
      add(I_IDLE, O_HLT,  M_ALL,   5,  3);  // 21
      add(I_IDLE, O_NORM, M_ALL,   5,  3);  // 22
      add(I_HALT | I_MW,   O_MW,   M_ALL, 5, 3); // 23 halt deferred
      add(I_HALT | I_MW,   O_MW,   M_ALL, 6, 3); // 24
      add(I_HALT | I_MRDY, O_NORM, M_ALL, 7, 3); // 25 leaves wait -> RUN
      add(I_HALT, O_NORM, M_ALL,   7,  3);  // 26 now honoured
      add(I_IDLE, O_HLT,  M_ALL,   7,  3);  // 27
      add(I_IDLE, O_NORM, M_ALL,   7,  3);  // 28

      for (int i = 0; i < vq.size(); i++) begin
         set_in(vq[i].in);
         $display("vec %0d in=%b a=%b b=%b stall=%0d/%0d flush=%0d/%0d",
                  i, vq[i].in, out_a, out_b, ifa.stall_cnt, ifb.stall_cnt,
                  ifa.flush_cnt, ifb.flush_cnt);
         chk_out($sformatf("v%0d_a", i), out_a, vq[i].exp, vq[i].mask);
         chk_out($sformatf("v%0d_b", i), out_b, vq[i].exp, vq[i].mask);
         if (vq[i].stall >= 0) begin
            chk_val($sformatf("v%0d_a_stall", i), int'(ifa.stall_cnt), vq[i].stall);
            chk_val($sformatf("v%0d_b_stall", i), int'(ifb.stall_cnt), vq[i].stall);
         end
         if (vq[i].flush >= 0) begin
            chk_val($sformatf("v%0d_a_flush", i), int'(ifa.flush_cnt), vq[i].flush);
            chk_val($sformatf("v%0d_b_flush", i), int'(ifb.flush_cnt), vq[i].flush);
         end
      end

      //---------------- T4: memory-wait timeout ----------------
      set_in(I_RST);
      for (int k = 1; k <= 6; k++) begin
         set_in(I_MW);
         $display("timeout wait %0d a=%b b=%b", k, ifa.mem_timeout, ifb.mem_timeout);
         chk_val($sformatf("to_w%0d_b", k), int'(ifb.mem_timeout), (k >= 5) ? 1 : 0);
         chk_val($sformatf("to_w%0d_a", k), int'(ifa.mem_timeout), 0);
         chk_out($sformatf("to_w%0d_b_out", k), out_b, O_MW, M_NOST);
      end
      set_in(I_MRDY);
      $display("timeout ready a=%b b=%b stall=%0d", ifa.mem_timeout, ifb.mem_timeout, ifb.stall_cnt);
      chk_val("to_rdy_b", int'(ifb.mem_timeout), 1);
      chk_val("to_rdy_b_stall", int'(ifb.stall_cnt), 6);
      chk_val("to_rdy_a_stall", int'(ifa.stall_cnt), 6);
      set_in(I_IDLE);
      $display("timeout after a=%b b=%b", ifa.mem_timeout, ifb.mem_timeout);
      chk_val("to_hold_b", int'(ifb.mem_timeout), 1);
      set_in(I_RST);
      chk_out("to_rst_b", out_b, O_RST, M_NOST);
      set_in(I_IDLE);
      $display("timeout cleared a=%b b=%b", ifa.mem_timeout, ifb.mem_timeout);
      chk_val("to_clr_b", int'(ifb.mem_timeout), 0);
      chk_val("to_clr_b_stall", int'(ifb.stall_cnt), 0);

      //---------------- T6: saturation, reset out of MEM_WAIT ----------------
      for (int k = 0; k < 9; k++) set_in(I_HDU);
      set_in(I_IDLE);
      $display("sat stall a=%0d b=%0d", ifa.stall_cnt, ifb.stall_cnt);
      chk_val("sat_b", int'(ifb.stall_cnt), 7);
      chk_val("sat_a", int'(ifa.stall_cnt), 9);
      set_in(I_MW);
      set_in(I_MW);
      chk_val("sat_mw_b", int'(ifb.stall_cnt), 7);
      chk_val("sat_mw_a", int'(ifa.stall_cnt), 10);
      set_in(I_RST | I_MW | I_HALT);
      chk_out("rst_mw_b", out_b, O_RST, M_NOST);
      set_in(I_HALT);
      $display("post reset a=%b b=%b stall=%0d", out_a, out_b, ifb.stall_cnt);
      chk_out("rst_mw_run_b", out_b, O_NORM, M_ALL);
      chk_val("rst_mw_cnt_b", int'(ifb.stall_cnt), 0);
      chk_val("rst_mw_cnt_a", int'(ifa.stall_cnt), 0);
      set_in(I_HALT);
      chk_out("rst_mw_halt_b", out_b, O_HLT, M_ALL);
      chk_out("rst_mw_halt_a", out_a, O_HLT, M_ALL);

      //---------------- reset out of HALTED ----------------
      set_in(I_RST | I_HALT);
      chk_out("rst_h_b", out_b, O_RST, M_NOST);
      set_in(I_HALT);
      $display("post halt reset a=%b b=%b", out_a, out_b);
      chk_out("rst_h_run_b", out_b, O_NORM, M_ALL);
      chk_out("rst_h_run_a", out_a, O_NORM, M_ALL);
      set_in(I_IDLE);
      chk_out("rst_h_hlt_b", out_b, O_HLT, M_ALL);
      set_in(I_IDLE);
      chk_out("rst_h_end_b", out_b, O_NORM, M_ALL);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
